// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: state codes, opcodes,
// ALU/immediate codes and the datapath mux select codes.
package riscv_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        MC_ST_IDLE      = 4'd0,
        MC_ST_FETCH     = 4'd1,
        MC_ST_DECODE    = 4'd2,
        MC_ST_MEMADR    = 4'd3,
        MC_ST_MEMRD     = 4'd4,
        MC_ST_MEMWB     = 4'd5,
        MC_ST_MEMWR     = 4'd6,
        MC_ST_EXEC      = 4'd7,
        MC_ST_ALUWB     = 4'd8,
        MC_ST_BRANCH    = 4'd9,
        MC_ST_JAL       = 4'd10,
        MC_ST_JALR      = 4'd11,
        MC_ST_JALR_LINK = 4'd12,
        MC_ST_LUI       = 4'd13,
        MC_ST_AUIPC     = 4'd14,
        MC_ST_TRAP      = 4'd15
    } mc_state_t;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_R_OP   = 7'b0110011;
    localparam logic [6:0] OPCODE_I_OP   = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd2;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd3;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd4;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd8;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd9;

    localparam logic [2:0] SRC_IMM_I = 3'd0;
    localparam logic [2:0] SRC_IMM_S = 3'd1;
    localparam logic [2:0] SRC_IMM_B = 3'd2;
    localparam logic [2:0] SRC_IMM_U = 3'd3;
    localparam logic [2:0] SRC_IMM_J = 3'd4;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;
    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;
    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_A_RS1   = 2'b10;
    localparam logic [1:0] ALU_B_RS2   = 2'b00;
    localparam logic [1:0] ALU_B_IMM   = 2'b01;
    localparam logic [1:0] ALU_B_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    // Branch outcome from the flags of the SUB/SLT/SLTU compare.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lsb);
        case (funct3)
            3'b000:          branch_taken = zero;
            3'b001:          branch_taken = !zero;
            3'b100, 3'b110:  branch_taken = lsb;
            3'b101, 3'b111:  branch_taken = !lsb;
            default:         branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_ctrl_alu_dec.sv
// Combinational field decode: ALU op for EXEC and BRANCH, immediate format,
// and memory byte lanes. The FSM picks which result applies per state.
module riscv_mc_ctrl_alu_dec
    import riscv_mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5b,
    output logic [3:0] exec_alu_ctrl,
    output logic [3:0] branch_alu_ctrl,
    output logic [2:0] src_imm,
    output logic [3:0] byte_sel
);

    always_comb begin
        exec_alu_ctrl   = ALU_CTRL_ADD;
        branch_alu_ctrl = ALU_CTRL_ADD;
        src_imm         = SRC_IMM_I;
        byte_sel        = 4'b1111;

        // IR[30] is a real funct7 bit for R-type, but for I-type only SRAI uses it.
        case (funct3)
            3'b000:  exec_alu_ctrl = (opcode == OPCODE_R_OP && funct7_5b) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            3'b001:  exec_alu_ctrl = ALU_CTRL_SLL;
            3'b010:  exec_alu_ctrl = ALU_CTRL_SLT;
            3'b011:  exec_alu_ctrl = ALU_CTRL_SLTU;
            3'b100:  exec_alu_ctrl = ALU_CTRL_XOR;
            3'b101:  exec_alu_ctrl = funct7_5b ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            3'b110:  exec_alu_ctrl = ALU_CTRL_OR;
            default: exec_alu_ctrl = ALU_CTRL_AND;
        endcase

        case (funct3)
            3'b000, 3'b001: branch_alu_ctrl = ALU_CTRL_SUB;
            3'b100, 3'b101: branch_alu_ctrl = ALU_CTRL_SLT;
            3'b110, 3'b111: branch_alu_ctrl = ALU_CTRL_SLTU;
            default:        branch_alu_ctrl = ALU_CTRL_ADD;
        endcase

        case (funct3[1:0])
            2'b00:   byte_sel = 4'b0001;
            2'b01:   byte_sel = 4'b0011;
            default: byte_sel = 4'b1111;
        endcase

        case (opcode)
            OPCODE_STORE:              src_imm = SRC_IMM_S;
            OPCODE_BRANCH:             src_imm = SRC_IMM_B;
            OPCODE_LUI, OPCODE_AUIPC:  src_imm = SRC_IMM_U;
            OPCODE_JAL:                src_imm = SRC_IMM_J;
            default:                   src_imm = SRC_IMM_I;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: state register plus Moore output decode
// driving the shared ALU, regfile, PC/IR and the shared memory port.
module riscv_mc_ctrl
    import riscv_mc_ctrl_pkg::*;
#(
    parameter logic MEM_WAIT_EN  = 1'b1,
    parameter logic ILLEGAL_HALT = 1'b1
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5b,
    input  logic       i_alu_zero,
    input  logic       i_alu_lsb,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_wr_en,
    output logic [3:0] o_mem_byte_sel,
    output logic       o_adr_src,
    output logic       o_ir_wr_en,
    output logic       o_pc_wr_en,
    output logic       o_pc_src,
    output logic       o_reg_wr_en,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_ctrl,
    output logic [2:0] o_src_imm,
    output logic [1:0] o_result_src,
    output logic       o_instr_done,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    mc_state_t  state_reg, state_next;
    logic       mem_ready;
    logic [3:0] exec_alu_ctrl, branch_alu_ctrl, byte_sel;
    logic [2:0] src_imm;

    assign mem_ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;
    assign o_state   = state_reg;

    riscv_mc_ctrl_alu_dec u_alu_dec (
        .opcode          (i_opcode),
        .funct3          (i_funct3),
        .funct7_5b       (i_funct7_5b),
        .exec_alu_ctrl   (exec_alu_ctrl),
        .branch_alu_ctrl (branch_alu_ctrl),
        .src_imm         (src_imm),
        .byte_sel        (byte_sel)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= MC_ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        o_mem_req      = 1'b0;
        o_mem_wr_en    = 1'b0;
        o_mem_byte_sel = 4'b0000;
        o_adr_src      = ADR_PC;
        o_ir_wr_en     = 1'b0;
        o_pc_wr_en     = 1'b0;
        o_pc_src       = PC_SRC_ALU;
        o_reg_wr_en    = 1'b0;
        o_alu_src_a    = ALU_A_PC;
        o_alu_src_b    = ALU_B_RS2;
        o_alu_ctrl     = ALU_CTRL_ADD;
        o_src_imm      = SRC_IMM_I;
        o_result_src   = RES_ALUOUT;
        o_instr_done   = 1'b0;
        o_illegal      = 1'b0;

        case (state_reg)
            MC_ST_IDLE: state_next = MC_ST_FETCH;
            MC_ST_FETCH: begin
                o_mem_req      = 1'b1;
                o_mem_byte_sel = 4'b1111;
                o_alu_src_b    = ALU_B_FOUR;
                if (mem_ready) begin
                    o_ir_wr_en = 1'b1;
                    o_pc_wr_en = 1'b1;
                    state_next = MC_ST_DECODE;
                end
            end
            MC_ST_DECODE: begin
                // Branch/JAL target is computed here and parked in ALUOut.
                o_alu_src_a = ALU_A_OLDPC;
                o_alu_src_b = ALU_B_IMM;
                o_src_imm   = src_imm;
                case (i_opcode)
                    OPCODE_LOAD, OPCODE_STORE: state_next = MC_ST_MEMADR;
                    OPCODE_R_OP, OPCODE_I_OP:  state_next = MC_ST_EXEC;
                    OPCODE_BRANCH:             state_next = MC_ST_BRANCH;
                    OPCODE_JAL:                state_next = MC_ST_JAL;
                    OPCODE_JALR:               state_next = MC_ST_JALR;
                    OPCODE_LUI:                state_next = MC_ST_LUI;
                    OPCODE_AUIPC:              state_next = MC_ST_AUIPC;
                    default:                   state_next = MC_ST_TRAP;
                endcase
            end
            MC_ST_MEMADR: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = ALU_B_IMM;
                o_src_imm   = src_imm;
                state_next  = (i_opcode == OPCODE_LOAD) ? MC_ST_MEMRD : MC_ST_MEMWR;
            end
            MC_ST_MEMRD: begin
                o_mem_req      = 1'b1;
                o_adr_src      = ADR_ALUOUT;
                o_mem_byte_sel = byte_sel;
                if (mem_ready) state_next = MC_ST_MEMWB;
            end
            MC_ST_MEMWB: begin
                o_reg_wr_en  = 1'b1;
                o_result_src = RES_MEM;
                o_instr_done = 1'b1;
                state_next   = MC_ST_FETCH;
            end
            MC_ST_MEMWR: begin
                o_mem_req      = 1'b1;
                o_mem_wr_en    = 1'b1;
                o_adr_src      = ADR_ALUOUT;
                o_mem_byte_sel = byte_sel;
                if (mem_ready) begin
                    o_instr_done = 1'b1;
                    state_next   = MC_ST_FETCH;
                end
            end
            MC_ST_EXEC: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = (i_opcode == OPCODE_R_OP) ? ALU_B_RS2 : ALU_B_IMM;
                o_alu_ctrl  = exec_alu_ctrl;
                o_src_imm   = src_imm;
                state_next  = MC_ST_ALUWB;
            end
            MC_ST_ALUWB: begin
                o_reg_wr_en  = 1'b1;
                o_result_src = RES_ALUOUT;
                o_instr_done = 1'b1;
                state_next   = MC_ST_FETCH;
            end
            MC_ST_BRANCH: begin
                o_alu_src_a  = ALU_A_RS1;
                o_alu_src_b  = ALU_B_RS2;
                o_alu_ctrl   = branch_alu_ctrl;
                o_pc_src     = PC_SRC_ALUOUT;
                o_pc_wr_en   = branch_taken(i_funct3, i_alu_zero, i_alu_lsb);
                o_instr_done = 1'b1;
                state_next   = MC_ST_FETCH;
            end
            MC_ST_JAL: begin
                o_pc_wr_en  = 1'b1;
                o_pc_src    = PC_SRC_ALUOUT;
                o_alu_src_a = ALU_A_OLDPC;
                o_alu_src_b = ALU_B_FOUR;
                state_next  = MC_ST_ALUWB;
            end
            MC_ST_JALR: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = ALU_B_IMM;
                o_src_imm   = src_imm;
                o_pc_wr_en  = 1'b1;
                state_next  = MC_ST_JALR_LINK;
            end
            MC_ST_JALR_LINK: begin
                o_alu_src_a  = ALU_A_OLDPC;
                o_alu_src_b  = ALU_B_FOUR;
                o_reg_wr_en  = 1'b1;
                o_result_src = RES_ALU;
                o_instr_done = 1'b1;
                state_next   = MC_ST_FETCH;
            end
            MC_ST_LUI: begin
                o_reg_wr_en  = 1'b1;
                o_result_src = RES_IMM;
                o_instr_done = 1'b1;
                state_next   = MC_ST_FETCH;
            end
            MC_ST_AUIPC: begin
                o_alu_src_a = ALU_A_OLDPC;
                o_alu_src_b = ALU_B_IMM;
                o_src_imm   = src_imm;
                state_next  = MC_ST_ALUWB;
            end
            MC_ST_TRAP: begin
                // PC was already advanced in FETCH, so resuming skips the bad word.
                o_illegal = 1'b1;
                if (!ILLEGAL_HALT) state_next = MC_ST_FETCH;
            end
            default: state_next = MC_ST_IDLE;
        endcase
    end

endmodule
